// File: rtl/hi_sniffer_agg.sv
`default_nettype none
// ============================================================================
// Module      : hi_sniffer_agg
// Description : HF sniffer front end. Samples the ADC once per ssp_clk cycle
//               and serialises one word per SSP frame to the ARM, LSB first.
//               The frame length is 2^FRAME_LEN_LOG2 slots. Each word is the
//               raw sample, or the max, min or average of the previous frame.
//               Streaming starts once enabled and adc_d reaches trig_level.
//               The field driver outputs are always off.
// Ports       : ck_1356meg  - 13.56 MHz clock, the only clock
//               reset       - asynchronous, active-high reset
//               adc_d       - ADC sample
//               enable      - sniffer enable, synchronous to ssp_clk
//               mode        - 00 raw, 01 max, 10 min, 11 avg
//               trig_level  - start threshold (0 = start immediately)
//               adc_clk     - ADC clock (= ck_1356meg)
//               ssp_clk     - SSP clock (= ~ck_1356meg)
//               ssp_din     - serial data, LSB first
//               ssp_frame   - high for slot 0 of each frame
//               streaming   - high while in the STREAM state
//               pwr_*       - field driver controls, tied low
// Options     : HI_SNIFF_SEQ_TAG_EN - puts a TAG_W-bit frame sequence number
//               in word bits [ADC_W+TAG_W-1:ADC_W]
// Revision    : 1.0 - initial release
// ============================================================================
module hi_sniffer_agg #(
  parameter int ADC_W          = 8,
  parameter int FRAME_LEN_LOG2 = 3,
  parameter int TAG_W          = 4
) (
  input  logic             ck_1356meg,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc_d,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [ADC_W-1:0] trig_level,
  output logic             adc_clk,
  output logic             ssp_clk,
  output logic             ssp_din,
  output logic             ssp_frame,
  output logic             streaming,
  output logic             pwr_lo,
  output logic             pwr_hi,
  output logic             pwr_oe1,
  output logic             pwr_oe2,
  output logic             pwr_oe3,
  output logic             pwr_oe4
);

  localparam int c_FRAME_LEN = 1 << FRAME_LEN_LOG2;
  localparam int c_SUM_W     = ADC_W + FRAME_LEN_LOG2;
  localparam logic [FRAME_LEN_LOG2-1:0] c_CNT_LAST = '1;

  // Parameter sanity checks, evaluated at elaboration.
  generate
    if (c_FRAME_LEN < ADC_W) begin : g_len_chk
      $error("hi_sniffer_agg: 2^FRAME_LEN_LOG2 must be >= ADC_W");
    end
`ifdef HI_SNIFF_SEQ_TAG_EN
    if (c_FRAME_LEN < ADC_W + TAG_W) begin : g_tag_chk
      $error("hi_sniffer_agg: 2^FRAME_LEN_LOG2 must be >= ADC_W+TAG_W");
    end
`else
    if (TAG_W < 1) begin : g_tagw_chk
      $error("hi_sniffer_agg: TAG_W must be >= 1");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [FRAME_LEN_LOG2-1:0]   r_cnt;
  logic [c_FRAME_LEN-1:0]      r_shreg;
  logic                        r_frame;
  logic                        r_win_vld;
  logic [ADC_W-1:0]            r_max;
  logic [ADC_W-1:0]            r_min;
  logic [c_SUM_W-1:0]          r_sum;
  logic [ADC_W-1:0]            w_result;
  logic [c_FRAME_LEN-1:0]      w_word;
  logic                        w_streaming;
`ifdef HI_SNIFF_SEQ_TAG_EN
  logic [TAG_W-1:0]            r_tag;
`endif

  // Clock passthrough and field driver off.
  assign adc_clk   = ck_1356meg;
  assign ssp_clk   = ~ck_1356meg;
  assign ssp_din   = r_shreg[0];
  assign ssp_frame = r_frame;
  assign streaming = w_streaming;
  assign pwr_lo    = 1'b0;
  assign pwr_hi    = 1'b0;
  assign pwr_oe1   = 1'b0;
  assign pwr_oe2   = 1'b0;
  assign pwr_oe3   = 1'b0;
  assign pwr_oe4   = 1'b0;

  // State register; everything advances on posedge ssp_clk.
  always_ff @(negedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A disabled stream leaves only at the frame wrap, so
  // the frame in flight always completes.
  always_comb begin
    w_state_nxt = r_state;
    w_streaming = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable)                 w_state_nxt = ST_IDLE;
        else if (adc_d >= trig_level) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        w_streaming = 1'b1;
        if ((r_cnt == c_CNT_LAST) && !enable) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Word for the frame starting now. Aggregate modes report the window
  // gathered over the previous frame; before one exists they report 0.
  always_comb begin
    w_result = '0;
    case (mode)
      2'b00: w_result = adc_d;
      2'b01: w_result = r_win_vld ? r_max : '0;
      2'b10: w_result = r_win_vld ? r_min : '0;
      2'b11: w_result = r_win_vld ? r_sum[c_SUM_W-1:FRAME_LEN_LOG2] : '0;
      default: w_result = '0;
    endcase
    w_word = '0;
    w_word[ADC_W-1:0] = w_result;
`ifdef HI_SNIFF_SEQ_TAG_EN
    w_word[ADC_W+TAG_W-1:ADC_W] = r_tag;
`endif
  end

  // Datapath: slot counter, shift register, frame marker and window.
  always_ff @(negedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_frame   <= 1'b0;
      r_win_vld <= 1'b0;
      r_max     <= '0;
      r_min     <= '0;
      r_sum     <= '0;
`ifdef HI_SNIFF_SEQ_TAG_EN
      r_tag     <= '0;
`endif
    end else if (r_state == ST_STREAM) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == '0) begin
        r_shreg   <= w_word;
        r_frame   <= 1'b1;
        r_win_vld <= 1'b1;
        // Slot-0 sample seeds the new window.
        r_max     <= adc_d;
        r_min     <= adc_d;
        r_sum     <= {{FRAME_LEN_LOG2{1'b0}}, adc_d};
`ifdef HI_SNIFF_SEQ_TAG_EN
        r_tag     <= r_tag + 1'b1;
`endif
      end else begin
        r_shreg <= {1'b0, r_shreg[c_FRAME_LEN-1:1]};
        r_frame <= 1'b0;
        if (adc_d > r_max) r_max <= adc_d;
        if (adc_d < r_min) r_min <= adc_d;
        r_sum   <= r_sum + {{FRAME_LEN_LOG2{1'b0}}, adc_d};
      end
    end else begin
      // IDLE / ARMED: quiet outputs, empty window, tag restarts at 0.
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_frame   <= 1'b0;
      r_win_vld <= 1'b0;
      r_max     <= '0;
      r_min     <= '0;
      r_sum     <= '0;
`ifdef HI_SNIFF_SEQ_TAG_EN
      r_tag     <= '0;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hi_sniffer_agg.sv
`default_nettype none
// ============================================================================
// Module      : tb_hi_sniffer_agg
// Description : Directed self-checking bench for hi_sniffer_agg (default
//               parameters: ADC_W=8, 8-slot frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hi_sniffer_agg;

  logic       ck_1356meg;
  logic       reset;
  logic [7:0] adc_d;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] trig_level;
  logic       adc_clk, ssp_clk, ssp_din, ssp_frame, streaming;
  logic       pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4;

  int n_vec = 0;
  int n_err = 0;

  hi_sniffer_agg u_dut (
    .ck_1356meg (ck_1356meg),
    .reset      (reset),
    .adc_d      (adc_d),
    .enable     (enable),
    .mode       (mode),
    .trig_level (trig_level),
    .adc_clk    (adc_clk),
    .ssp_clk    (ssp_clk),
    .ssp_din    (ssp_din),
    .ssp_frame  (ssp_frame),
    .streaming  (streaming),
    .pwr_lo     (pwr_lo),
    .pwr_hi     (pwr_hi),
    .pwr_oe1    (pwr_oe1),
    .pwr_oe2    (pwr_oe2),
    .pwr_oe3    (pwr_oe3),
    .pwr_oe4    (pwr_oe4)
  );

  initial ck_1356meg = 1'b0;
  always #5 ck_1356meg = ~ck_1356meg;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past one active (falling) edge and let outputs settle.
  task automatic tick();
    @(negedge ck_1356meg);
    #2;
  endtask

  // Feed one 8-slot window starting at a cnt==0 edge while capturing the
  // word emitted at that edge and the ssp_frame pattern.
  task automatic feed_frame(input logic [7:0] s [8], input string tag,
                            input logic [7:0] exp_w);
    logic [7:0] w;
    logic [7:0] f;
    for (int i = 0; i < 8; i++) begin
      adc_d = s[i];
      tick();
      w[i] = ssp_din;
      f[i] = ssp_frame;
    end
    check_val({tag, "_word"}, {24'd0, w}, {24'd0, exp_w});
    check_val({tag, "_frm"},  {24'd0, f}, 32'h01);
  endtask

  logic [7:0] s_a5 [8] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
  logic [7:0] s_a  [8] = '{8'd3, 8'd9, 8'd4, 8'd200, 8'd7, 8'd0, 8'd1, 8'd2};
  logic [7:0] s_b  [8] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
  logic [7:0] s_c  [8] = '{8'h5A, 8'h11, 8'hF0, 8'h22, 8'h33, 8'h01, 8'h44, 8'h55};
  logic [7:0] s_d  [8] = '{8'h81, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    logic [7:0] w;
    logic [7:0] sv;
    logic       any;
    int         found;

    // ---- reset state ----
    reset = 1'b1; enable = 1'b0; mode = 2'b00; trig_level = 8'h00; adc_d = 8'h00;
    tick();
    check_val("rst_frame",  {31'd0, ssp_frame}, 32'd0);
    check_val("rst_stream", {31'd0, streaming}, 32'd0);
    check_val("rst_din",    {31'd0, ssp_din},   32'd0);
    check_val("clk_pass",   {30'd0, adc_clk, ssp_clk}, {30'd0, ck_1356meg, ~ck_1356meg});
    check_val("pwr_off",    {26'd0, pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4}, 32'd0);

    // ---- raw mode, constant 0xA5 ----
    enable = 1'b1; adc_d = 8'hA5; reset = 1'b0;
    tick();                         // IDLE -> ARMED
    tick();                         // ARMED -> STREAM
    check_val("raw_start", {30'd0, streaming, ssp_frame}, 32'h2);
    feed_frame(s_a5, "raw1", 8'hA5);
    feed_frame(s_a5, "raw2", 8'hA5);

    // ---- asynchronous reset mid-stream ----
    tick(); tick(); tick();
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    check_val("mrst_async", {29'd0, ssp_frame, streaming, ssp_din}, 32'd0);
    tick();
    check_val("mrst_next",  {29'd0, ssp_frame, streaming, ssp_din}, 32'd0);
    reset = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      any = any | streaming | ssp_frame | ssp_din;
    end
    check_val("mrst_idle", {31'd0, any}, 32'd0);

    // ---- aggregation modes ----
    reset = 1'b1; mode = 2'b01; trig_level = 8'h00; enable = 1'b1; adc_d = 8'h00;
    tick();
    reset = 1'b0;
    tick(); tick();
    check_val("agg_start", {30'd0, streaming, ssp_frame}, 32'h2);
    feed_frame(s_a, "max_empty", 8'h00);
    feed_frame(s_a, "max_a", 8'hC8);
    mode = 2'b10; feed_frame(s_b, "min_a", 8'h00);
    mode = 2'b11; feed_frame(s_c, "avg_b", 8'h2D);
    mode = 2'b01; feed_frame(s_a, "max_c", 8'hF0);
    mode = 2'b11; feed_frame(s_b, "avg_a", 8'h1C);
    mode = 2'b00; feed_frame(s_c, "raw_c", 8'h5A);
    mode = 2'b10; feed_frame(s_a, "min_c", 8'h01);

    // ---- trigger on ramp ----
    reset = 1'b1; mode = 2'b00; trig_level = 8'h80; enable = 1'b1; adc_d = 8'h00;
    tick();
    reset = 1'b0;
    tick();                         // IDLE -> ARMED
    found = -1;
    any = 1'b0;
    for (int v = 0; v < 256; v++) begin
      adc_d = v[7:0];
      tick();
      if (streaming) begin
        found = v;
        break;
      end
      any = any | ssp_frame;
    end
    check_val("trig_level", found, 32'h80);
    check_val("trig_quiet", {31'd0, any}, 32'd0);
    check_val("trig_frm0",  {31'd0, ssp_frame}, 32'd0);
    feed_frame(s_d, "trig_first", 8'h81);

    // ---- enable drop at cnt=3 ----
    for (int i = 0; i < 8; i++) begin
      if (i == 3) enable = 1'b0;
      adc_d = (i == 0) ? 8'h96 : 8'h00;
      tick();
      w[i]  = ssp_din;
      sv[i] = streaming;
    end
    check_val("drop_word",   {24'd0, w},  32'h96);
    check_val("drop_stream", {24'd0, sv}, 32'h7F);
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any = any | streaming | ssp_frame | ssp_din;
    end
    check_val("drop_idle", {31'd0, any}, 32'd0);

    // ---- re-enable, trigger immediately above threshold ----
    enable = 1'b1; adc_d = 8'hFF;
    tick();                         // IDLE -> ARMED
    tick();                         // ARMED -> STREAM
    check_val("reen_stream", {31'd0, streaming}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
